// File: rtl/online_add_sequencer.sv
// rtl/online_add_sequencer.sv - drives one online radix-4 addition and collects result digits; ONLINE_ADD_SEQ_CHECK_EN enables the result check
module online_add_sequencer #(
    parameter int N     = 6,
    parameter int C     = 3,
    parameter int DELAY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N*C-1:0]       x,
    input  logic [N*C-1:0]       y,
    input  logic [(N+1)*C-1:0]   expected,
    input  logic [C-1:0]         zi,
    output logic [C-1:0]         xi,
    output logic [C-1:0]         yi,
    output logic                 adder_reset,
    output logic                 adder_en,
    output logic [(N+1)*C-1:0]   result,
    output logic                 busy,
    output logic                 done,
    output logic                 correct
);

    localparam int KW = $clog2(N + DELAY + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N + DELAY - 1);
    localparam logic [KW-1:0] K_CAP0 = KW'(DELAY - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [KW-1:0]        r_k;
    logic [N*C-1:0]       r_x;
    logic [N*C-1:0]       r_y;
    logic [(N+1)*C-1:0]   r_result;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_cap;
    logic [KW-1:0]        w_d;
    logic [C-1:0]         w_xd;
    logic [C-1:0]         w_yd;
    logic [(N+1)*C-1:0]   w_result_next;

    // abort beats start, so a simultaneous request never leaves IDLE
    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_last   = (r_state == S_RUN) && (r_k == K_LAST);
    // the adder's first output digit appears DELAY-1 cycles into RUN
    assign w_cap    = (r_state == S_RUN) && (r_k >= K_CAP0);
    assign w_d      = r_k - K_CAP0;

    // pick operand digit k (MSD first); past the last digit the operands are zero
    always_comb begin
        w_xd = '0;
        w_yd = '0;
        for (int i = 0; i < N; i++) begin
            if (r_k == KW'(i)) begin
                w_xd = r_x[(N - i) * C - 1 -: C];
                w_yd = r_y[(N - i) * C - 1 -: C];
            end
        end
    end

    // slot the incoming adder digit into its result position
    always_comb begin
        w_result_next = r_result;
        for (int d = 0; d <= N; d++) begin
            if (w_cap && (w_d == KW'(d))) begin
                w_result_next[(N + 1 - d) * C - 1 -: C] = zi;
            end
        end
    end

    // control FSM, run counter, operand latch and result collection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x      <= x;
                        r_y      <= y;
                        r_result <= '0;
                        r_k      <= '0;
                        r_state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_k     <= '0;
                    r_state <= abort ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (abort) begin
                        // partial digits stay visible; the aborted edge captures nothing
                        r_k     <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_result_next;
                        if (w_last) begin
                            r_k     <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                default: begin
                    r_k     <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign adder_reset = (r_state == S_CLEAR);
    assign adder_en    = (r_state == S_RUN);
    assign done        = (r_state == S_DONE) && !abort;
    assign xi          = (r_state == S_RUN) ? w_xd : '0;
    assign yi          = (r_state == S_RUN) ? w_yd : '0;
    assign result      = r_result;

`ifdef ONLINE_ADD_SEQ_CHECK_EN
    logic [(N+1)*C-1:0] r_expected;
    logic               r_correct;

    // latch the reference on start; judge the full result as it is completed so it is valid with done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expected <= '0;
            r_correct  <= 1'b0;
        end else if (w_accept) begin
            r_expected <= expected;
            r_correct  <= 1'b0;
        end else if (abort && (r_state != S_IDLE)) begin
            r_correct <= 1'b0;
        end else if (w_last) begin
            r_correct <= (w_result_next == r_expected);
        end
    end

    assign correct = r_correct;
`else
    // no comparator in this build; expected has no consumer and correct is constant 0
    assign correct = 1'b0 & (^expected);
`endif

endmodule

// File: tb/tb_online_add_sequencer.sv
// tb/tb_online_add_sequencer.sv - directed vector bench for online_add_sequencer
module tb_online_add_sequencer;

    localparam int N     = 6;
    localparam int C     = 3;
    localparam int DELAY = 2;
    localparam int W     = N * C;
    localparam int RW    = (N + 1) * C;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [RW-1:0] expected;
    logic [C-1:0]  zi;
    logic [C-1:0]  xi;
    logic [C-1:0]  yi;
    logic          adder_reset;
    logic          adder_en;
    logic [RW-1:0] result;
    logic          busy;
    logic          done;
    logic          correct;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [RW-1:0] zseq = '0;
    int            env_k = 0;

    typedef struct {
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [RW-1:0] z;
        logic [RW-1:0] exp_in;
        logic [RW-1:0] res;
        logic          ok;
    } vec_t;

    vec_t vt[4];

    always #5 clk = ~clk;

    online_add_sequencer #(.N(N), .C(C), .DELAY(DELAY)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .x(x), .y(y), .expected(expected), .zi(zi),
        .xi(xi), .yi(yi), .adder_reset(adder_reset), .adder_en(adder_en),
        .result(result), .busy(busy), .done(done), .correct(correct)
    );

    // adder stand-in: emits zseq digit k-1 during RUN cycle k
    always @(posedge clk) begin
        if (adder_reset) env_k <= 0;
        else if (adder_en) env_k <= env_k + 1;
    end

    always_comb begin
        zi = '0;
        if (adder_en && env_k >= 1 && env_k <= N + 1)
            zi = zseq[RW - 1 - (env_k - 1) * C -: C];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_ok(input logic ok);
`ifdef ONLINE_ADD_SEQ_CHECK_EN
        return ok;
`else
        return 1'b0 & ok;
`endif
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " adder_en"}, adder_en, 0);
        chk({tag, " adder_reset"}, adder_reset, 0);
        chk({tag, " xi"}, xi, 0);
        chk({tag, " yi"}, yi, 0);
        chk({tag, " result"}, result, 0);
        chk({tag, " correct"}, correct, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [C-1:0] ex, ey;
        x = v.x; y = v.y; expected = v.exp_in; zseq = v.z;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " c1 adder_reset"}, adder_reset, 1);
        chk({tag, " c1 adder_en"}, adder_en, 0);
        chk({tag, " c1 busy"}, busy, 1);
        chk({tag, " c1 xi"}, xi, 0);
        chk({tag, " c1 result cleared"}, result, 0);
        chk({tag, " c1 correct cleared"}, correct, 0);
        for (int k = 0; k < N + DELAY; k++) begin
            tick();
            ex = '0; ey = '0;
            if (k < N) begin
                ex = v.x[W - 1 - k * C -: C];
                ey = v.y[W - 1 - k * C -: C];
            end
            chk({tag, " run adder_en"}, adder_en, 1);
            chk({tag, " run adder_reset"}, adder_reset, 0);
            chk({tag, " run done"}, done, 0);
            chk({tag, " run xi"}, xi, ex);
            chk({tag, " run yi"}, yi, ey);
        end
        tick();
        chk({tag, " c10 done"}, done, 1);
        chk({tag, " c10 adder_en"}, adder_en, 0);
        chk({tag, " c10 busy"}, busy, 1);
        chk({tag, " c10 result"}, result, v.res);
        chk({tag, " c10 correct"}, correct, exp_ok(v.ok));
        tick();
        chk({tag, " c11 busy"}, busy, 0);
        chk({tag, " c11 done"}, done, 0);
        chk({tag, " c11 result"}, result, v.res);
        chk({tag, " c11 correct"}, correct, exp_ok(v.ok));
    endtask

    initial begin
        int dcount, done_cyc, cyc;

        vt[0] = '{18'o000000, 18'o000000, 21'o0000000, 21'o0000000, 21'o0000000, 1'b1};
        vt[1] = '{18'o111111, 18'o111111, 21'o0222222, 21'o0222222, 21'o0222222, 1'b1};
        vt[2] = '{18'o111111, 18'o111111, 21'o0222222, 21'o0222223, 21'o0222222, 1'b0};
        vt[3] = '{18'o777777, 18'o123456, 21'o7654321, 21'o7654321, 21'o7654321, 1'b1};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        x = '0; y = '0; expected = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
            repeat (2) tick();
            chk($sformatf("vec%0d hold result", i), result, vt[i].res);
            chk($sformatf("vec%0d hold correct", i), correct, exp_ok(vt[i].ok));
        end

        // start re-asserted in RUN cycle 4 must be ignored
        x = vt[1].x; y = vt[1].y; expected = vt[1].exp_in; zseq = vt[1].z;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; dcount = 0; done_cyc = 0;
        while (cyc < 16) begin
            start = (cyc == 6);
            tick();
            cyc++;
            if (done) begin dcount++; done_cyc = cyc; end
        end
        start = 1'b0;
        chk("restart done count", dcount, 1);
        chk("restart done cycle", done_cyc, 10);
        chk("restart busy after", busy, 0);

        // abort in RUN cycle 3
        x = vt[3].x; y = vt[3].y; expected = vt[3].exp_in; zseq = vt[3].z;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort adder_en", adder_en, 0);
        chk("abort done", done, 0);
        chk("abort partial result", result, 21'o7600000);
        chk("abort correct", correct, 0);
        dcount = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done || adder_en) dcount++;
        end
        chk("abort no later activity", dcount, 0);

        // reset asserted in RUN cycle 5
        x = vt[1].x; y = vt[1].y; expected = vt[1].exp_in; zseq = vt[1].z;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre-reset adder_en", adder_en, 1);
        #2 reset = 1'b1;
        #1;
        chk_idle_zero("midrun reset");
        tick();
        reset = 1'b0;
        run_vec(vt[3], "after reset");

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        dcount = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (busy || adder_reset) dcount++;
        end
        start = 1'b0; abort = 1'b0;
        chk("start+abort no run", dcount, 0);
        chk("start+abort result kept", result, vt[3].res);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/online_add_sequencer.md
ONLINE_ADD_SEQUENCER -- requirements
Module: online_add_sequencer

Interface
REQ-001 Parameters SHALL be: N, 6, operand digits; C, 3, bits per signed digit; DELAY, 2, online delay of the adder.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-004 start  in  1  request to run one addition; sampled only in IDLE.
REQ-005 abort  in  1  cancel current operation.
REQ-006 x, y  in  N*C each  signed-digit operands, digit 0 (MSD) at bits [N*C-1 -: C].
REQ-007 expected  in  (N+1)*C  reference sum, same digit packing.
REQ-008 zi  in  C  result digit from online_adder_r4, valid in the current cycle.
REQ-009 xi, yi  out  C each  operand digits to the adder.
REQ-010 adder_reset  out  1  synchronous clear pulse to the adder.
REQ-011 adder_en  out  1  adder step enable.
REQ-012 result  out  (N+1)*C  collected sum digits, digit 0 at MSB end.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 correct  out  1  result equals expected, valid from done until next start.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, RUN, DONE; a run counter k of width clog2(N+DELAY+1) SHALL index RUN cycles.
REQ-017 IDLE: start=1 and abort=0 SHALL latch x, y, expected, clear result and correct to 0, go to CLEAR.
REQ-018 CLEAR: lasts exactly one cycle with adder_reset=1, adder_en=0, xi=yi=0; next RUN with k=0.
REQ-019 RUN: lasts exactly N+DELAY cycles (k=0..N+DELAY-1) with adder_en=1, adder_reset=0.
REQ-020 RUN cycle k<N SHALL drive xi/yi = latched digit k; k>=N SHALL drive xi=yi=0.
REQ-021 RUN cycle k>=DELAY-1 SHALL capture zi into result digit d=k-(DELAY-1) at bits [(N+1-d)*C-1 -: C] on the closing edge; exactly N+1 digits captured.
REQ-022 After last RUN cycle -> DONE for one cycle: done=1, adder_en=0, correct updated per REQ-031; next IDLE.
REQ-023 Total latency start-edge to done-high SHALL be N+DELAY+2 cycles (10 at defaults).
REQ-024 start while busy SHALL be ignored, not queued.
REQ-025 abort in CLEAR, RUN or DONE SHALL force IDLE on the next edge, adder_en=0, no done pulse, result retains partial digits, correct=0.
REQ-026 start and abort both high in IDLE: abort wins, no run begins.
REQ-027 Outside RUN, adder_en=0 and xi=yi=0; adder_reset high only in CLEAR.
REQ-028 result and correct SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-029 reset=1 SHALL asynchronously force IDLE, k=0, latched operands=0, result=0, xi=yi=0, adder_reset=0, adder_en=0, busy=0, done=0, correct=0.
REQ-030 reset asserted mid-run SHALL abandon the run with no done pulse; first start after release runs a full CLEAR sequence.

Configuration
REQ-031 Macro ONLINE_ADD_SEQ_CHECK_EN defined: correct SHALL be registered (result == expected) in DONE; undefined: comparator omitted, correct tied 0, expected ignored, all other behaviour identical.

Verification
REQ-032 Reset release, start high one cycle at edge 0 -> adder_reset=1 cycle 1, adder_en=1 cycles 2-9, done=1 cycle 10 only, busy=1 cycles 1-10.
REQ-033 x=y=0, expected=0 with real online_adder_r4 -> result=0, correct=1 (macro defined), correct=0 (undefined).
REQ-034 x=all digits +1, y=all digits +1, expected=correct sum -> correct=1; corrupt expected LSB digit -> correct=0.
REQ-035 start re-asserted during RUN cycle 4 -> ignored, done exactly once at cycle 10; abort at RUN cycle 3 -> IDLE next cycle, no done, adder_en=0.
REQ-036 reset asserted at RUN cycle 5 -> all outputs at reset values immediately; subsequent start gives full 10-cycle sequence.
REQ-037 start and abort high together in IDLE -> busy stays 0, adder_reset never asserted.
